// File: rtl/cla_nibble_accumulator.sv
// cla_nibble_accumulator: signed WIDTH-bit accumulator (acc += operand), one 4-bit CLA group per clock
//   Ports: clk, reset (async, active-high), clr (zero acc, IDLE only),
//          in_valid/in_data/in_ready (operand handshake), acc (accumulator),
//          out_valid (one-cycle completion pulse), ovf (signed overflow of last sum, valid with out_valid),
//          ovf_sticky (any overflow since clr/reset).
//   Build option: define SATURATE_EN to clamp acc to the signed limit on overflow.
module cla_nibble_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] acc,
    output logic             out_valid,
    output logic             ovf,
    output logic             ovf_sticky
);
    localparam int N  = WIDTH / 4;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ADD, SETTLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, old_sign_q, old_sign_d;
    logic             out_valid_q, out_valid_d, ovf_q, ovf_d, sticky_q, sticky_d;
    logic [3:0]       a, b, g, p, sum;
    logic             c1, c2, c3, c4, ovf_c, accept;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid & in_ready;
    assign acc        = acc_q;
    assign out_valid  = out_valid_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

    // 4-bit lookahead slice on the current group
    always_comb begin
        a   = acc_q[{idx_q, 2'b00} +: 4];
        b   = op_q[{idx_q, 2'b00} +: 4];
        g   = a & b;
        p   = a ^ b;
        c1  = g[0] | (p[0] & carry_q);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum = p ^ {c3, c2, c1, carry_q};
    end

    assign ovf_c = (op_q[WIDTH-1] == old_sign_q) & (acc_q[WIDTH-1] != op_q[WIDTH-1]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        old_sign_d  = old_sign_q;
        sticky_d    = sticky_q;
        out_valid_d = 1'b0;
        ovf_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    acc_d    = '0;
                    sticky_d = 1'b0;
                end
                if (accept) begin
                    op_d       = in_data;
                    old_sign_d = clr ? 1'b0 : acc_q[WIDTH-1];
                    idx_d      = '0;
                    carry_d    = 1'b0;
                    state_d    = ADD;
                end
            end
            ADD: begin
                acc_d[{idx_q, 2'b00} +: 4] = sum;
                carry_d = c4;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IW'(N - 1)) ? SETTLE : ADD;
            end
            SETTLE: begin
                // sum is complete; flag overflow and publish on the next edge
                out_valid_d = 1'b1;
                ovf_d       = ovf_c;
                sticky_d    = sticky_q | ovf_c;
`ifdef SATURATE_EN
                if (ovf_c)
                    acc_d = old_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            old_sign_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            old_sign_q  <= old_sign_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end
endmodule

// File: tb/tb_cla_nibble_accumulator.sv
// tb_cla_nibble_accumulator: directed self-checking bench for cla_nibble_accumulator (WIDTH=32)
module tb_cla_nibble_accumulator;
    logic        clk = 1'b0, reset, clr, in_valid;
    logic [31:0] in_data;
    logic        in_ready, out_valid, ovf, ovf_sticky;
    logic [31:0] acc;
    int checks = 0, errors = 0;

`ifdef SATURATE_EN
    localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
`endif

    cla_nibble_accumulator #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .acc(acc), .out_valid(out_valid), .ovf(ovf), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand, then sample #1 after each edge (sample 0 = accept edge) until back in IDLE.
    task automatic run_op(input logic [31:0] d, input logic c, output int lat, output int busy,
                          output int pulses, output logic [31:0] av, output logic ov);
        @(negedge clk);
        in_data = d; clr = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        lat = -1; busy = 0; pulses = 0; av = 'x; ov = 1'bx;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (!in_ready) busy++;
            if (out_valid) begin
                pulses++;
                if (lat < 0) begin lat = i; av = acc; ov = ovf; end
            end
            if (in_ready && i > 0) break;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] d, input logic c,
                      input logic [31:0] exp_acc, input logic exp_ovf);
        int lat, busy, pulses;
        logic [31:0] av;
        logic ov;
        run_op(d, c, lat, busy, pulses, av, ov);
        check({tag, " acc"}, av, exp_acc);
        check({tag, " ovf"}, {31'd0, ov}, {31'd0, exp_ovf});
        check({tag, " latency"}, lat, 32'd9);
        check({tag, " busy"}, busy, 32'd10);
        check({tag, " pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int idx1, idx2, acc_idx, pulses;
        logic [31:0] acc1, acc2;
        logic seen_ready;
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        check("reset acc", acc, 32'h0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        check("reset sticky", {31'd0, ovf_sticky}, 32'd0);
        @(negedge clk); reset = 1'b0;

        op("carry0", 32'h0000_000F, 1'b0, 32'h0000_000F, 1'b0);
        op("carry1", 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0);

        op("ripple0", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        op("ripple1", 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0);

        op("pos0", 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0);
        op("posovf", 32'h0000_0001, 1'b0, POS_OVF, 1'b1);
        check("posovf sticky", {31'd0, ovf_sticky}, 32'd1);

        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midreset acc", acc, 32'h0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset sticky", {31'd0, ovf_sticky}, 32'd0);
        @(negedge clk); reset = 1'b0;

        op("neg0", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0);
        op("negovf", 32'hFFFF_FFFF, 1'b0, NEG_OVF, 1'b1);
        check("negovf sticky", {31'd0, ovf_sticky}, 32'd1);
        op("clracc", 32'h0000_0005, 1'b1, 32'h0000_0005, 1'b0);
        check("clracc sticky", {31'd0, ovf_sticky}, 32'd0);

        // operand 3 accepted; 0x20 held valid and clr pulsed during ADD must wait / be ignored
        @(negedge clk);
        in_data = 32'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 32'h20; clr = 1'b1;
        idx1 = -1; idx2 = -1; acc_idx = -1; acc1 = 'x; acc2 = 'x; seen_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 3) clr = 1'b0;
            if (out_valid && idx1 < 0) begin idx1 = i; acc1 = acc; end
            else if (out_valid && idx2 < 0) begin idx2 = i; acc2 = acc; end
            if (in_ready) seen_ready = 1'b1;
            if (seen_ready && !in_ready && in_valid) begin in_valid = 1'b0; acc_idx = i; end
            if (idx2 >= 0) break;
        end
        in_valid = 1'b0; clr = 1'b0;
        check("hs first latency", idx1, 32'd9);
        check("hs first acc", acc1, 32'h0000_0008);
        check("hs second accept", acc_idx, 32'd11);
        check("hs second latency", idx2, 32'd20);
        check("hs second acc", acc2, 32'h0000_0028);

        // abort during group 3
        @(negedge clk);
        in_data = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort acc", acc, 32'h0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
            if (i == 2) begin @(negedge clk); reset = 1'b0; end
        end
        check("abort no pulse", pulses, 32'd0);
        check("abort acc idle", acc, 32'h0);
        op("after abort", 32'h0000_0002, 1'b0, 32'h0000_0002, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
